// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep sequencer for the DDS core: steps Fword from F_start to F_stop,
// holding each point Dwell+2 cycles, in single, repeating-sawtooth or triangle mode.
module dds_sweep_ctrl #(
  parameter int unsigned FW = 32,
  parameter int unsigned PW = 12,
  parameter int unsigned DW = 24
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          Abort,
  input  logic [1:0]    Mode,
  input  logic [FW-1:0] F_start,
  input  logic [FW-1:0] F_stop,
  input  logic [FW-1:0] F_step,
  input  logic [DW-1:0] Dwell,
  input  logic [PW-1:0] Pword_in,
  input  logic [1:0]    Wave_in,
  output logic [FW-1:0] Fword,
  output logic [PW-1:0] Pword,
  output logic [1:0]    Module_Sel,
  output logic          Busy,
  output logic          Done,
  output logic          Dir
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DWELL = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [FW-1:0] fstart_q, fstart_d;
  logic [FW-1:0] fstop_q, fstop_d;
  logic [FW-1:0] fstep_q, fstep_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [PW-1:0] pw_q, pw_d;
  logic [1:0]    wave_q, wave_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fword_d;
  logic [PW-1:0] pword_d;
  logic [1:0]    msel_d;
  logic          busy_d, done_d, dir_d;

  // Clamped neighbours of the current point, computed one bit wider so they never wrap
  logic [FW:0]   up_sum, down_diff;
  logic [FW-1:0] up_val, down_val;
  logic          degenerate;

  always_comb begin
    up_sum    = {1'b0, Fword} + {1'b0, fstep_q};
    down_diff = {1'b0, Fword} - {1'b0, fstep_q};
    up_val    = (up_sum >= {1'b0, fstop_q}) ? fstop_q : up_sum[FW-1:0];
    down_val  = (down_diff[FW] || (down_diff[FW-1:0] <= fstart_q)) ? fstart_q
                                                                   : down_diff[FW-1:0];
    degenerate = (fstep_q == '0) || (fstart_q >= fstop_q);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    fstart_d = fstart_q;
    fstop_d  = fstop_q;
    fstep_d  = fstep_q;
    dwell_d  = dwell_q;
    pw_d     = pw_q;
    wave_d   = wave_q;
    cnt_d    = cnt_q;
    fword_d  = Fword;
    pword_d  = Pword;
    msel_d   = Module_Sel;
    busy_d   = Busy;
    dir_d    = Dir;
    done_d   = 1'b0;

    if (state_q != S_IDLE && Abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start && !Abort) begin
            mode_d   = Mode;
            fstart_d = F_start;
            fstop_d  = F_stop;
            fstep_d  = F_step;
            dwell_d  = Dwell;
            pw_d     = Pword_in;
            wave_d   = Wave_in;
            busy_d   = 1'b1;
            state_d  = S_LOAD;
          end
        end
        S_LOAD: begin
          fword_d = fstart_q;
          pword_d = pw_q;
          msel_d  = wave_q;
          dir_d   = 1'b0;
          cnt_d   = dwell_q;
          state_d = S_DWELL;
        end
        S_DWELL: begin
          if (cnt_q == '0) begin
            state_d = S_STEP;
          end else begin
            cnt_d = cnt_q - DW'(1);
          end
        end
        S_STEP: begin
          cnt_d   = dwell_q;
          state_d = S_DWELL;
          if (degenerate) begin
            state_d = S_DONE;
          end else if (!Dir) begin
            if (Fword != fstop_q) begin
              fword_d = up_val;
            end else if (mode_q == 2'd1) begin
              fword_d = fstart_q;
            end else if (mode_q == 2'd2) begin
              dir_d   = 1'b1;
              fword_d = down_val;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            if (Fword != fstart_q) begin
              fword_d = down_val;
            end else begin
              dir_d   = 1'b0;
              fword_d = up_val;
            end
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      fstart_q   <= '0;
      fstop_q    <= '0;
      fstep_q    <= '0;
      dwell_q    <= '0;
      pw_q       <= '0;
      wave_q     <= '0;
      cnt_q      <= '0;
      Fword      <= '0;
      Pword      <= '0;
      Module_Sel <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Dir        <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      fstart_q   <= fstart_d;
      fstop_q    <= fstop_d;
      fstep_q    <= fstep_d;
      dwell_q    <= dwell_d;
      pw_q       <= pw_d;
      wave_q     <= wave_d;
      cnt_q      <= cnt_d;
      Fword      <= fword_d;
      Pword      <= pword_d;
      Module_Sel <= msel_d;
      Busy       <= busy_d;
      Done       <= done_d;
      Dir        <= dir_d;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: expected sweep points (value, hold length)
// and Done pulses are queued by the stimulus and matched by a negedge monitor.
module tb_dds_sweep_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start, Abort;
  logic [1:0]  Mode;
  logic [31:0] F_start, F_stop, F_step;
  logic [23:0] Dwell;
  logic [11:0] Pword_in;
  logic [1:0]  Wave_in;
  logic [31:0] Fword;
  logic [11:0] Pword;
  logic [1:0]  Module_Sel;
  logic        Busy, Done, Dir;

  dds_sweep_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Abort(Abort), .Mode(Mode),
    .F_start(F_start), .F_stop(F_stop), .F_step(F_step), .Dwell(Dwell),
    .Pword_in(Pword_in), .Wave_in(Wave_in), .Fword(Fword), .Pword(Pword),
    .Module_Sel(Module_Sel), .Busy(Busy), .Done(Done), .Dir(Dir)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          is_done;
    logic [31:0] fw;
    logic [11:0] pw;
    logic [1:0]  ms;
    logic        dir;
    int          len;
  } item_t;

  item_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_pt(input logic [31:0] fw, input logic [11:0] pw, input logic [1:0] ms,
                        input logic dir, input int len);
    item_t it;
    it.is_done = 1'b0; it.fw = fw; it.pw = pw; it.ms = ms; it.dir = dir; it.len = len;
    exp_q.push_back(it);
  endtask

  task automatic exp_done();
    item_t it;
    it.is_done = 1'b1; it.fw = '0; it.pw = '0; it.ms = '0; it.dir = 1'b0; it.len = 0;
    exp_q.push_back(it);
  endtask

  // Compare one observed item against the scoreboard head
  task automatic score(input item_t obs);
    item_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_%s: fw=0x%0h len=%0d with empty queue at %0t",
               obs.is_done ? "done" : "point", obs.fw, obs.len, $time);
      return;
    end
    e = exp_q.pop_front();
    chk("kind", 32'(obs.is_done), 32'(e.is_done));
    if (!e.is_done && !obs.is_done) begin
      chk("fword", obs.fw, e.fw);
      chk("hold_len", 32'(obs.len), 32'(e.len));
      chk("dir", 32'(obs.dir), 32'(e.dir));
      chk("pword", 32'(obs.pw), 32'(e.pw));
      chk("module_sel", 32'(obs.ms), 32'(e.ms));
    end else if (obs.is_done) begin
      chk("busy_at_done", 32'(Busy), 32'd0);
    end
  endtask

  // Monitor: the first Busy cycle is LOAD; later Busy cycles are grouped into runs of constant Fword/Dir
  initial begin
    item_t run;
    item_t dn;
    bit run_valid = 1'b0;
    bit prev_busy = 1'b0;
    forever begin
      @(negedge Clk);
      if (Busy && !prev_busy) begin
        run_valid = 1'b0;
      end else if (Busy) begin
        if (run_valid && run.fw === Fword && run.dir === Dir) begin
          run.len++;
        end else begin
          if (run_valid) score(run);
          run.is_done = 1'b0; run.fw = Fword; run.pw = Pword; run.ms = Module_Sel;
          run.dir = Dir; run.len = 1;
          run_valid = 1'b1;
        end
      end else if (run_valid) begin
        score(run);
        run_valid = 1'b0;
      end
      if (Done === 1'b1) begin
        dn.is_done = 1'b1; dn.fw = Fword; dn.pw = Pword; dn.ms = Module_Sel;
        dn.dir = Dir; dn.len = 0;
        score(dn);
      end
      prev_busy = Busy;
    end
  end

  task automatic nwait(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Start pulse sampled at one posedge; returns at the following negedge
  task automatic start_sweep(input logic [1:0] m, input logic [31:0] fs, input logic [31:0] fp,
                             input logic [31:0] st, input logic [23:0] dw,
                             input logic [11:0] pw, input logic [1:0] wv);
    @(negedge Clk);
    Mode = m; F_start = fs; F_stop = fp; F_step = st; Dwell = dw;
    Pword_in = pw; Wave_in = wv; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0; Start = 1'b0; Abort = 1'b0; Mode = '0;
    F_start = '0; F_stop = '0; F_step = '0; Dwell = '0; Pword_in = '0; Wave_in = '0;
    nwait(3);
    chk("rst_fword", Fword, 32'd0);
    chk("rst_pword", 32'(Pword), 32'd0);
    chk("rst_msel", 32'(Module_Sel), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_dir", 32'(Dir), 32'd0);
    Reset_n = 1'b1;
    nwait(2);

    // Single sweep, evenly divided span
    for (int i = 1; i <= 3; i++) exp_pt(32'(100 * i), 12'h011, 2'd1, 1'b0, 4);
    exp_pt(32'd400, 12'h011, 2'd1, 1'b0, 5);
    exp_done();
    start_sweep(2'd0, 32'd100, 32'd400, 32'd100, 24'd2, 12'h011, 2'd1);
    nwait(25);
    chk("t1_busy_after", 32'(Busy), 32'd0);
    chk("t1_fword_hold", Fword, 32'd400);

    // Last point clamped to F_stop
    exp_pt(32'd0, 12'h022, 2'd2, 1'b0, 2);
    exp_pt(32'd100, 12'h022, 2'd2, 1'b0, 2);
    exp_pt(32'd200, 12'h022, 2'd2, 1'b0, 2);
    exp_pt(32'd250, 12'h022, 2'd2, 1'b0, 3);
    exp_done();
    start_sweep(2'd0, 32'd0, 32'd250, 32'd100, 24'd0, 12'h022, 2'd2);
    nwait(15);

    // Triangle with abort during the sixth point
    exp_pt(32'd10, 12'h123, 2'd2, 1'b0, 2);
    exp_pt(32'd20, 12'h123, 2'd2, 1'b0, 2);
    exp_pt(32'd30, 12'h123, 2'd2, 1'b0, 2);
    exp_pt(32'd20, 12'h123, 2'd2, 1'b1, 2);
    exp_pt(32'd10, 12'h123, 2'd2, 1'b1, 2);
    exp_pt(32'd20, 12'h123, 2'd2, 1'b0, 1);
    start_sweep(2'd2, 32'd10, 32'd30, 32'd10, 24'd0, 12'h123, 2'd2);
    nwait(11);
    Abort = 1'b1;
    nwait(1);
    Abort = 1'b0;
    chk("t3_busy_abort", 32'(Busy), 32'd0);
    chk("t3_fword_abort", Fword, 32'd20);
    chk("t3_done_abort", 32'(Done), 32'd0);
    nwait(4);
    chk("t3_done_later", 32'(Done), 32'd0);

    // Top-of-range sweep must not wrap
    exp_pt(32'hFFFF_FF00, 12'h044, 2'd0, 1'b0, 2);
    exp_pt(32'hFFFF_FF80, 12'h044, 2'd0, 1'b0, 2);
    exp_pt(32'hFFFF_FFFF, 12'h044, 2'd0, 1'b0, 3);
    exp_done();
    start_sweep(2'd3, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 24'd0, 12'h044, 2'd0);
    nwait(15);
    chk("t4_fword_final", Fword, 32'hFFFF_FFFF);

    // Zero step: one point, Done seven cycles after Start
    exp_pt(32'd555, 12'hABC, 2'd3, 1'b0, 6);
    exp_done();
    start_sweep(2'd1, 32'd555, 32'd900, 32'd0, 24'd3, 12'hABC, 2'd3);
    nwait(6);
    chk("t5_done_early", 32'(Done), 32'd0);
    nwait(1);
    chk("t5_done_at7", 32'(Done), 32'd1);
    chk("t5_pword", 32'(Pword), 32'hABC);
    chk("t5_msel", 32'(Module_Sel), 32'd3);
    nwait(5);

    // Start together with Abort in IDLE starts nothing
    Start = 1'b1; Abort = 1'b1;
    nwait(1);
    Start = 1'b0; Abort = 1'b0;
    chk("abort_start_busy", 32'(Busy), 32'd0);
    nwait(2);
    chk("abort_start_busy2", 32'(Busy), 32'd0);

    // Mid-sweep Start and F_stop change ignored, then synchronous reset
    exp_pt(32'd100, 12'h055, 2'd1, 1'b0, 4);
    exp_pt(32'd200, 12'h055, 2'd1, 1'b0, 4);
    exp_pt(32'd300, 12'h055, 2'd1, 1'b0, 1);
    start_sweep(2'd0, 32'd100, 32'd400, 32'd100, 24'd2, 12'h055, 2'd1);
    nwait(3);
    F_stop = 32'd200; Start = 1'b1;
    nwait(1);
    Start = 1'b0;
    nwait(5);
    Reset_n = 1'b0;
    nwait(1);
    chk("t6_fword_rst", Fword, 32'd0);
    chk("t6_pword_rst", 32'(Pword), 32'd0);
    chk("t6_msel_rst", 32'(Module_Sel), 32'd0);
    chk("t6_busy_rst", 32'(Busy), 32'd0);
    chk("t6_done_rst", 32'(Done), 32'd0);
    chk("t6_dir_rst", 32'(Dir), 32'd0);
    Reset_n = 1'b1;
    nwait(6);
    chk("t6_idle_busy", 32'(Busy), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
